// File: rtl/evt_counter_pkg.sv
// Shared types and constants for the modulo event counter bank.
package evt_counter_pkg;

  typedef enum logic {
    WR_COUNT = 1'b0,
    WR_MOD   = 1'b1
  } wr_sel_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Channel-select width; a single-channel bank still needs one select bit.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/evt_counter_bank_if.sv
// Event, control, write-bus and status signals of the event counter bank.
interface evt_counter_bank_if
  import evt_counter_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 17
);
  localparam int CH_W = ch_w(NUM_CH);

  logic [NUM_CH-1:0]            evt_in;
  logic [NUM_CH-1:0]            en_in;
  logic [NUM_CH-1:0]            dir_in;
  logic                         wr_valid_in;
  logic [CH_W-1:0]              wr_ch_in;
  wr_sel_t                      wr_sel_in;
  logic [WIDTH-1:0]             wr_data_in;
  logic [NUM_CH-1:0][WIDTH-1:0] count_out;
  logic [NUM_CH-1:0][WIDTH-1:0] mod_out;
  logic [NUM_CH-1:0]            wrap_out;

  modport master (
    output evt_in, en_in, dir_in, wr_valid_in, wr_ch_in, wr_sel_in, wr_data_in,
    input  count_out, mod_out, wrap_out
  );

  modport slave (
    input  evt_in, en_in, dir_in, wr_valid_in, wr_ch_in, wr_sel_in, wr_data_in,
    output count_out, mod_out, wrap_out
  );

endinterface

// File: rtl/evt_counter_bank_channel.sv
// One modulo event counter: count/modulus registers and the wrap decision.
module evt_counter_channel
  import evt_counter_pkg::*;
#(
  parameter int          WIDTH       = 17,
  parameter int unsigned DEFAULT_MOD = 115_200
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             evt_i,
  input  logic             dir_i,
  input  logic             wr_count_i,
  input  logic             wr_mod_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic [WIDTH-1:0] count_o,
  output logic [WIDTH-1:0] mod_o,
  output logic             wrap_next_o
);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] mod_q, mod_d;
  logic             wrap_d;

  // A write to this channel swallows a coincident event, which also keeps
  // wrap_d low so nothing cascades out of a written channel.
  always_comb begin
    count_d = count_q;
    mod_d   = mod_q;
    wrap_d  = 1'b0;
    if (wr_count_i) begin
      count_d = wr_data_i;
    end else if (wr_mod_i) begin
      mod_d = wr_data_i;
    end else if (evt_i) begin
      unique case (dir_i)
        DIR_UP: begin
          if (mod_q == '0) begin
            count_d = count_q + ONE;
            wrap_d  = (count_q == '1);
          end else if (count_q >= mod_q - ONE) begin
            count_d = '0;
            wrap_d  = 1'b1;
          end else begin
            count_d = count_q + ONE;
          end
        end
        DIR_DOWN: begin
          if (count_q == '0) begin
            count_d = mod_q - ONE;
            wrap_d  = 1'b1;
          end else begin
            count_d = count_q - ONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
      mod_q   <= WIDTH'(DEFAULT_MOD);
    end else begin
      count_q <= count_d;
      mod_q   <= mod_d;
    end
  end

  assign count_o     = count_q;
  assign mod_o       = mod_q;
  assign wrap_next_o = wrap_d;

endmodule

// File: rtl/evt_counter_bank.sv
// Bank of NUM_CH modulo event counters with a shared write port.
// Define EVT_COUNTER_BANK_CASCADE_EN to chain each channel's wrap into the next.
module evt_counter_bank
  import evt_counter_pkg::*;
#(
  parameter int          NUM_CH      = 4,
  parameter int          WIDTH       = 17,
  parameter int unsigned DEFAULT_MOD = 115_200
) (
  input  logic         clk_in,
  input  logic         rst_in,
  evt_counter_bank_if.slave bus
);
  localparam int CH_W = ch_w(NUM_CH);

  logic [NUM_CH-1:0] qual;
  logic [NUM_CH-1:0] wr_count;
  logic [NUM_CH-1:0] wr_mod;
  logic [NUM_CH-1:0] wrap_d;
  logic [NUM_CH-1:0] wrap_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic wr_hit;
    // Selects at or above NUM_CH never match any channel and are dropped.
    assign wr_hit      = bus.wr_valid_in && (bus.wr_ch_in == CH_W'(i));
    assign wr_count[i] = wr_hit && (bus.wr_sel_in == WR_COUNT);
    assign wr_mod[i]   = wr_hit && (bus.wr_sel_in == WR_MOD);

`ifdef EVT_COUNTER_BANK_CASCADE_EN
    if (i == 0) begin : g_head
      assign qual[i] = bus.evt_in[i] & bus.en_in[i];
    end else begin : g_link
      assign qual[i] = (bus.evt_in[i] | wrap_d[i-1]) & bus.en_in[i];
    end
`else
    assign qual[i] = bus.evt_in[i] & bus.en_in[i];
`endif

    evt_counter_channel #(
      .WIDTH       (WIDTH),
      .DEFAULT_MOD (DEFAULT_MOD)
    ) u_ch (
      .clk_i       (clk_in),
      .rst_i       (rst_in),
      .evt_i       (qual[i]),
      .dir_i       (bus.dir_in[i]),
      .wr_count_i  (wr_count[i]),
      .wr_mod_i    (wr_mod[i]),
      .wr_data_i   (bus.wr_data_in),
      .count_o     (bus.count_out[i]),
      .mod_o       (bus.mod_out[i]),
      .wrap_next_o (wrap_d[i])
    );
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) wrap_q <= '0;
    else        wrap_q <= wrap_d;
  end

  assign bus.wrap_out = wrap_q;

endmodule

// File: tb/tb_evt_counter_bank.sv
// Directed bench for evt_counter_bank (NUM_CH=4, WIDTH=4, DEFAULT_MOD=10);
// cascade expectations follow EVT_COUNTER_BANK_CASCADE_EN.
module tb_evt_counter_bank;
  import evt_counter_pkg::*;

  localparam int NCH = 4;
  localparam int W   = 4;
  localparam int DM  = 10;

  typedef struct {
    string tag;
    int    ch;
    int    cnt;
    int    wrp;
    int    md;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  evt_counter_bank_if #(.NUM_CH(NCH), .WIDTH(W)) bus ();

  evt_counter_bank #(
    .NUM_CH      (NCH),
    .WIDTH       (W),
    .DEFAULT_MOD (DM)
  ) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic expect_ch(input string tag, input int ch, input int cnt,
                           input int wrp, input int md = -1);
    exp_t e;
    e.tag = tag; e.ch = ch; e.cnt = cnt; e.wrp = wrp; e.md = md;
    sb.push_back(e);
  endtask

  // Advance one edge, sample 1 ns later, then retire all queued expectations.
  task automatic cycle();
    exp_t e;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      tests++;
      assert (bus.count_out[e.ch] === W'(e.cnt)) else begin
        fails++;
        $error("FAIL %s ch%0d count got %0d want %0d", e.tag, e.ch, bus.count_out[e.ch], e.cnt);
      end
      tests++;
      assert (bus.wrap_out[e.ch] === 1'(e.wrp)) else begin
        fails++;
        $error("FAIL %s ch%0d wrap got %0b want %0b", e.tag, e.ch, bus.wrap_out[e.ch], e.wrp);
      end
      if (e.md >= 0) begin
        tests++;
        assert (bus.mod_out[e.ch] === W'(e.md)) else begin
          fails++;
          $error("FAIL %s ch%0d mod got %0d want %0d", e.tag, e.ch, bus.mod_out[e.ch], e.md);
        end
      end
    end
    bus.wr_valid_in = 1'b0;
    bus.evt_in      = '0;
  endtask

  task automatic wr(input int ch, input wr_sel_t sel, input int data);
    bus.wr_valid_in = 1'b1;
    bus.wr_ch_in    = 2'(ch);
    bus.wr_sel_in   = sel;
    bus.wr_data_in  = W'(data);
  endtask

  initial begin
    bus.evt_in      = '0;
    bus.en_in       = '1;
    bus.dir_in      = '0;
    bus.wr_valid_in = 1'b0;
    bus.wr_ch_in    = '0;
    bus.wr_sel_in   = WR_COUNT;
    bus.wr_data_in  = '0;

    // Reset state
    for (int c = 0; c < NCH; c++) expect_ch("reset", c, 0, 0, DM);
    cycle();
    rst = 1'b0;

    // Ten up events on ch0 with M=10
    for (int k = 1; k <= 10; k++) begin
      bus.evt_in[0] = 1'b1;
      expect_ch("up_ch0", 0, k % 10, (k == 10) ? 1 : 0);
      expect_ch("idle_ch1", 1, 0, 0);
      cycle();
    end
    expect_ch("up_ch0_quiet", 0, 0, 0);
    cycle();

    // M=3 down-counting on ch1
    wr(1, WR_MOD, 3);
    expect_ch("wrmod_ch1", 1, 0, 0, 3);
    cycle();
    bus.dir_in[1] = DIR_DOWN;
    begin
      int seq_c[4] = '{2, 1, 0, 2};
      int seq_w[4] = '{1, 0, 0, 1};
      for (int k = 0; k < 4; k++) begin
        bus.evt_in[1] = 1'b1;
        expect_ch("down_ch1", 1, seq_c[k], seq_w[k]);
        cycle();
      end
    end

    // Out-of-range count going down decrements without wrapping
    wr(1, WR_COUNT, 6);
    expect_ch("oor_wr_ch1", 1, 6, 0, 3);
    cycle();
    bus.evt_in[1] = 1'b1;
    expect_ch("oor_down_ch1", 1, 5, 0);
    cycle();
    bus.dir_in[1] = DIR_UP;
    bus.evt_in[1] = 1'b1;
    expect_ch("oor_up_ch1", 1, 0, 1);
    cycle();

    // Write wins over a coincident event; other channels still count
    wr(2, WR_COUNT, 7);
    bus.evt_in[2] = 1'b1;
    bus.evt_in[3] = 1'b1;
    expect_ch("wr_wins_ch2", 2, 7, 0);
    expect_ch("neighbor_ch3", 3, 1, 0);
    cycle();

    // Disabled channel ignores events
    bus.en_in[3]  = 1'b0;
    bus.evt_in[3] = 1'b1;
    expect_ch("disabled_ch3", 3, 1, 0);
    cycle();
    bus.en_in[3] = 1'b1;

    // Full-range modulus (M=0) wraps at 15
    wr(0, WR_MOD, 0);
    expect_ch("mod0_ch0", 0, 0, 0, 0);
    cycle();
    wr(0, WR_COUNT, 15);
    expect_ch("cnt15_ch0", 0, 15, 0);
    cycle();
    bus.evt_in[0] = 1'b1;
    expect_ch("full_wrap_ch0", 0, 0, 1);
    cycle();

    // M=1 wraps on every event
    wr(0, WR_MOD, 1);
    expect_ch("mod1_ch0", 0, 0, 0, 1);
    cycle();
    for (int k = 0; k < 3; k++) begin
      bus.evt_in[0] = 1'b1;
      expect_ch("m1_ch0", 0, 0, 1);
      cycle();
    end
    expect_ch("m1_quiet_ch0", 0, 0, 0);
    cycle();

    // Cascade 9,9 -> 0,0
    wr(0, WR_MOD, 10);   cycle();
    wr(1, WR_MOD, 10);   cycle();
    wr(0, WR_COUNT, 9);  cycle();
    wr(1, WR_COUNT, 9);
    expect_ch("preset_ch0", 0, 9, 0, 10);
    expect_ch("preset_ch1", 1, 9, 0, 10);
    cycle();
    bus.evt_in[0] = 1'b1;
    expect_ch("casc_ch0", 0, 0, 1);
`ifdef EVT_COUNTER_BANK_CASCADE_EN
    expect_ch("casc_ch1", 1, 0, 1);
`else
    expect_ch("casc_ch1", 1, 9, 0);
`endif
    cycle();

    // A write to ch0 drops its event and so also any cascade into ch1
    wr(0, WR_COUNT, 9);  cycle();
    wr(1, WR_COUNT, 9);  cycle();
    wr(0, WR_MOD, 10);
    bus.evt_in[0] = 1'b1;
    expect_ch("drop_ch0", 0, 9, 0, 10);
    expect_ch("drop_ch1", 1, 9, 0);
    cycle();

    // Reset overrides a simultaneous write and events
    bus.evt_in = '1;
    wr(2, WR_MOD, 5);
    rst = 1'b1;
    for (int c = 0; c < NCH; c++) expect_ch("rst_mid", c, 0, 0, DM);
    cycle();
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/evt_counter_bank.md
# evt_counter_bank

Parametrised bank of independent modulo event counters: the multi-channel, run-time-configurable generation of the single-channel event counter. Each channel counts qualified events up or down modulo a per-channel modulus, accepts software writes of count and modulus, and emits a one-cycle wrap pulse. Sits between timing sources (baud ticks, divider ticks, PPU/APU strobes) and the logic that consumes periodic ticks or rollovers.

## Interface
- `NUM_CH`, 4: number of channels, 1..16.
- `WIDTH`, 17: count/modulus width per channel.
- `DEFAULT_MOD`, 115_200: modulus loaded into every channel at reset; must satisfy 1 ≤ DEFAULT_MOD ≤ 2^WIDTH−1.
- `clk_in` in, 1: single clock.
- `rst_in` in, 1: synchronous, active-high reset.
- `evt_in` in, NUM_CH: per-channel event strobe.
- `en_in` in, NUM_CH: per-channel enable; events are ignored while low.
- `dir_in` in, NUM_CH: 0 = count up, 1 = count down.
- `wr_valid_in` in, 1: write strobe, always accepted.
- `wr_ch_in` in, $clog2(NUM_CH) (min 1): target channel.
- `wr_sel_in` in, 1: `WR_COUNT` (0) or `WR_MOD` (1).
- `wr_data_in` in, WIDTH: write data.
- `count_out` out, NUM_CH×WIDTH: registered counts.
- `mod_out` out, NUM_CH×WIDTH: registered moduli.
- `wrap_out` out, NUM_CH: registered wrap pulses.

## Operation
- Reset: all `count_out` = 0, all `mod_out` = DEFAULT_MOD, all `wrap_out` = 0. Reset overrides every other input.
- Qualified event for channel i: `evt_in[i] & en_in[i]`. With cascade enabled, see Configuration.
- Up: count == M−1 → 0 with wrap; otherwise +1.
- Down: count == 0 → M−1 with wrap; otherwise −1.
- M is `mod_out[i]`. M = 0 means full range 2^WIDTH: wrap at 2^WIDTH−1 going up and at 0 going down. M = 1 holds the count at 0 and wraps on every event.
- Out-of-range count (count ≥ M, M ≠ 0, reachable after a modulus write): an up event goes to 0 with wrap. A down event decrements normally and does not wrap unless count == 0.
- Write `WR_COUNT`: count ← `wr_data_in`, with no wrap. `WR_MOD`: modulus ← `wr_data_in`, and the count is unchanged.
- A write and a qualified event to the same channel in the same cycle: the write wins and the event is dropped. A `WR_MOD` write drops a coincident event only for that channel. Other channels count normally.
- `wr_ch_in` ≥ NUM_CH: the write is ignored.
- Changing `dir_in` takes effect on the next qualified event. No state is kept per direction.

## Timing
- Event at edge k → `count_out` updated after edge k (1-cycle latency).
- `wrap_out[i]` is high for exactly the one cycle in which `count_out[i]` first shows the wrapped value. Back-to-back wraps (M = 1, continuous events) hold `wrap_out` high continuously.
- Write at edge k → new value is visible after edge k.
- No combinational path from inputs to outputs.

## Configuration
- Macro: `EVT_COUNTER_BANK_CASCADE_EN`.
- Defined: for channel i > 0, the qualified event is `(evt_in[i] | wrap_next[i−1]) & en_in[i]`.
  - `wrap_next` is the combinational wrap decision of channel i−1 in the same cycle, so a chain rolls over atomically on one edge. Example: 9,9 → 0,0 with M = 10.
  - Channel 0 is unchanged.
  - A write dropping channel i−1's event also suppresses the cascade into channel i.
- Undefined: channels are fully independent and there is no inter-channel path.

## Structure
- Package `evt_counter_pkg`: `wr_sel_t` enum (`WR_COUNT`, `WR_MOD`) and the `DIR_UP`/`DIR_DOWN` constants.
- Sub-module `evt_counter_channel`: one channel, holding the count/modulus registers, wrap logic and a combinational `wrap_next` output. The bank generates NUM_CH instances, decodes writes and wires the cascade.

## Test plan
- Reset, then 10 events on ch0, NUM_CH = 4, WIDTH = 4, DEFAULT_MOD = 10, up → count steps 1..9, 0. `wrap_out[0]` is high only in the cycle count = 0.
- `WR_MOD` ch1 = 3, `dir_in[1]` = 1, 4 events → 0, 2, 1, 0, 2. The wrap pulses on the first and fourth updates.
- `WR_COUNT` ch2 = 7 and `evt_in[2]` in the same cycle → count = 7, no increment, no wrap. ch3 counts its coincident event normally.
- `WR_MOD` ch0 = 0, `WR_COUNT` = 15, one up event → 0 with wrap. `WR_MOD` = 1 plus 3 events → count stays 0 and `wrap_out` is high for 3 consecutive cycles.
- Cascade defined, all M = 10, ch0/ch1 preset to 9,9, one ch0 event → ch0/ch1 = 0,0 on the same edge, `wrap_out[1:0]` = 2'b11. Undefined → ch1 stays 9.
- Assert `rst_in` mid-count with a simultaneous write and event → all counts 0, moduli DEFAULT_MOD, `wrap_out` 0 the next cycle.
